// File: rtl/masked_sram_array_pkg.sv
// Shared types and sizing helpers for the segment-masked SRAM array.
package masked_sram_array_pkg;

    // Array controller states: clear sweep after reset, then serving requests.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Full entry width from segment count and segment width.
    function automatic int calc_data_w(input int segs, input int seg_w);
        return segs * seg_w;
    endfunction

    // Width of the sweep counter; at least one bit even for tiny arrays.
    function automatic int calc_cnt_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/masked_sram_core.sv
// Storage for the masked SRAM array: per-segment masked write and a
// registered read port. No reset; contents are defined by the clear sweep.
module masked_sram_core
    import masked_sram_array_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int SEGS   = 4,
    parameter int SEG_W  = 11
) (
    input  logic                    clock,
    input  logic                    we_i,
    input  logic                    re_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [SEGS-1:0]         wmask_i,
    input  logic [SEGS*SEG_W-1:0]   wdata_i,
    output logic [SEGS*SEG_W-1:0]   rdata_o
);

    localparam int DATA_W = calc_data_w(SEGS, SEG_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Masked write: only segments with their mask bit set are updated.
    always_ff @(posedge clock) begin
        if (we_i) begin
            for (int i = 0; i < SEGS; i++) begin
                if (wmask_i[i]) begin
                    mem_q[addr_i][i*SEG_W +: SEG_W] <= wdata_i[i*SEG_W +: SEG_W];
                end
            end
        end
    end

    // Read capture; the value is held until the next read is accepted.
    always_ff @(posedge clock) begin
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/masked_sram_array.sv
// Parametrised single-port segment-masked SRAM array with clear-on-reset
// sweep, selectable read latency (1 or 2), read-valid strobe and held data.
module masked_sram_array
    import masked_sram_array_pkg::*;
#(
    parameter int               DEPTH    = 128,
    parameter int               ADDR_W   = 7,
    parameter int               SEGS     = 4,
    parameter int               SEG_W    = 11,
    parameter int               RD_LAT   = 1,
    parameter logic [SEG_W-1:0] INIT_VAL = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       RW0_addr,
    input  logic                    RW0_en,
    input  logic                    RW0_wmode,
    input  logic [SEGS-1:0]         RW0_wmask,
    input  logic [SEGS*SEG_W-1:0]   RW0_wdata,
    output logic [SEGS*SEG_W-1:0]   RW0_rdata,
    output logic                    RW0_rvalid,
    output logic                    init_done
);

    localparam int DATA_W = calc_data_w(SEGS, SEG_W);
    localparam int CNT_W  = calc_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               sweep;
    logic               accept;
    logic               in_range;
    logic               rd_req;
    logic               wr_req;

    logic               core_we;
    logic               core_re;
    logic [ADDR_W-1:0]  core_addr;
    logic [SEGS-1:0]    core_wmask;
    logic [DATA_W-1:0]  core_wdata;
    logic [DATA_W-1:0]  core_rdata;

    logic               vld_p1_q;
    logic               zero_p1_q;
    logic [DATA_W-1:0]  rdata_p1;

    assign sweep     = (state_q == ST_CLEAR);
    assign init_done = !sweep;
    assign in_range  = (int'(RW0_addr) < DEPTH);
    assign accept    = !sweep && RW0_en;
    assign rd_req    = accept && !RW0_wmode;
    assign wr_req    = accept && RW0_wmode && in_range;

    // Sweep owns the array port while clearing; requesters are ignored.
    assign core_we    = sweep || wr_req;
    assign core_re    = rd_req && in_range;
    assign core_addr  = sweep ? ADDR_W'(cnt_q) : RW0_addr;
    assign core_wmask = sweep ? '1 : RW0_wmask;
    assign core_wdata = sweep ? {SEGS{INIT_VAL}} : RW0_wdata;

    // Sweep sequencing: step through every entry, then hand over to READY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sweep) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ST_READY;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Controller state; reset restarts the sweep from entry 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    masked_sram_core #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .SEGS   (SEGS),
        .SEG_W  (SEG_W)
    ) u_core (
        .clock   (clock),
        .we_i    (core_we),
        .re_i    (core_re),
        .addr_i  (core_addr),
        .wmask_i (core_wmask),
        .wdata_i (core_wdata),
        .rdata_o (core_rdata)
    );

    // Stage p1: read valid, plus a zero flag for out-of-range reads. The
    // flag also forces zero output after reset until the first read lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1_q  <= 1'b0;
            zero_p1_q <= 1'b1;
        end else begin
            vld_p1_q <= rd_req;
            if (rd_req) begin
                zero_p1_q <= !in_range;
            end
        end
    end

    assign rdata_p1 = zero_p1_q ? '0 : core_rdata;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              vld_p2_q;
            logic [DATA_W-1:0] rdata_p2_q;

            // Stage p2: optional output register, loaded only on read completion.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    vld_p2_q   <= 1'b0;
                    rdata_p2_q <= '0;
                end else begin
                    vld_p2_q <= vld_p1_q;
                    if (vld_p1_q) begin
                        rdata_p2_q <= rdata_p1;
                    end
                end
            end

            assign RW0_rvalid = vld_p2_q;
            assign RW0_rdata  = rdata_p2_q;
        end else begin : g_lat1
            assign RW0_rvalid = vld_p1_q;
            assign RW0_rdata  = rdata_p1;
        end
    endgenerate

endmodule

// File: tb/tb_masked_sram_array.sv
// Self-checking bench for masked_sram_array: three instances (DEPTH=128 lat 1,
// DEPTH=16 lat 2, DEPTH=100 lat 1) share the request bus; a scoreboard per
// instance holds expected read data and the cycle it must appear.
module tb_masked_sram_array;

    localparam int SW = 11;
    localparam int DW = 44;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic [2:0]    rst;
    logic [2:0]    en;
    logic [6:0]    addr;
    logic          wmode;
    logic [3:0]    wmask;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata [3];
    logic [2:0]    rvalid;
    logic [2:0]    init_done;

    int            cyc = 0;
    int            dep [3];
    int            lat [3];
    exp_t          sb_q [3][$];
    logic [DW-1:0] mdl [3][128];
    int            n_pass = 0;
    int            n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    masked_sram_array #(.DEPTH(128), .ADDR_W(7), .SEGS(4), .SEG_W(11), .RD_LAT(1), .INIT_VAL(11'h0)) u_d0 (
        .clock(clk), .reset(rst[0]), .RW0_addr(addr), .RW0_en(en[0]), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata[0]), .RW0_rvalid(rvalid[0]),
        .init_done(init_done[0]));

    masked_sram_array #(.DEPTH(16), .ADDR_W(7), .SEGS(4), .SEG_W(11), .RD_LAT(2), .INIT_VAL(11'h0)) u_d1 (
        .clock(clk), .reset(rst[1]), .RW0_addr(addr), .RW0_en(en[1]), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata[1]), .RW0_rvalid(rvalid[1]),
        .init_done(init_done[1]));

    masked_sram_array #(.DEPTH(100), .ADDR_W(7), .SEGS(4), .SEG_W(11), .RD_LAT(1), .INIT_VAL(11'h0)) u_d2 (
        .clock(clk), .reset(rst[2]), .RW0_addr(addr), .RW0_en(en[2]), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata[2]), .RW0_rvalid(rvalid[2]),
        .init_done(init_done[2]));

    // Scoreboard: every rvalid pops one expected entry; a late entry is missing.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rvalid[d] === 1'b1) begin
                n_total++;
                if (sb_q[d].size() == 0) begin
                    $display("FAIL rvalid_unexpected dut%0d cyc=%0d rdata=%h, no read pending", d, cyc, rdata[d]);
                end else begin
                    e = sb_q[d].pop_front();
                    if (rdata[d] !== e.data || cyc != e.due)
                        $display("FAIL read_data dut%0d got %h at cyc %0d, want %h at cyc %0d", d, rdata[d], cyc, e.data, e.due);
                    else
                        n_pass++;
                end
            end else if (sb_q[d].size() > 0 && sb_q[d][0].due < cyc) begin
                n_total++;
                $display("FAIL rvalid_missing dut%0d cyc=%0d, want %h due at cyc %0d", d, cyc, sb_q[d][0].data, sb_q[d][0].due);
                void'(sb_q[d].pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_model(input int d);
        for (int a = 0; a < 128; a++) mdl[d][a] = '0;
        sb_q[d].delete();
    endtask

    task automatic drive_read(input int d, input logic [6:0] a, input bit push);
        exp_t e;
        @(posedge clk); #1;
        en = '0; en[d] = 1'b1; wmode = 1'b0; addr = a; wmask = '0;
        if (push) begin
            e.data = (int'(a) < dep[d]) ? mdl[d][a] : '0;
            e.due  = cyc + lat[d];
            sb_q[d].push_back(e);
        end
    endtask

    task automatic drive_write(input int d, input logic [6:0] a, input logic [DW-1:0] data,
                               input logic [3:0] mask, input bit upd);
        @(posedge clk); #1;
        en = '0; en[d] = 1'b1; wmode = 1'b1; addr = a; wmask = mask; wdata = data;
        if (upd && int'(a) < dep[d]) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) mdl[d][a][i*SW +: SW] = data[i*SW +: SW];
        end
    endtask

    task automatic drive_idle(input int n);
        @(posedge clk); #1;
        en = '0; wmode = 1'b0; wmask = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int r;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_total++;
            if (rdata[d] !== '0) $display("FAIL reset_rdata dut%0d got %h want 0", d, rdata[d]); else n_pass++;
            n_total++;
            if (rvalid[d] !== 1'b0) $display("FAIL reset_rvalid dut%0d got %b want 0", d, rvalid[d]); else n_pass++;
            n_total++;
            if (init_done[d] !== 1'b0) $display("FAIL reset_init_done dut%0d got %b want 0", d, init_done[d]); else n_pass++;
            clear_model(d);
        end
        rst = '0;
        r = cyc;
        for (int i = 0; i < 131; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (cyc - r == dep[d] - 1) begin
                    n_total++;
                    if (init_done[d] !== 1'b0) $display("FAIL init_early dut%0d got %b want 0 at +%0d", d, init_done[d], cyc - r);
                    else n_pass++;
                end else if (cyc - r == dep[d]) begin
                    n_total++;
                    if (init_done[d] !== 1'b1) $display("FAIL init_rise dut%0d got %b want 1 at +%0d", d, init_done[d], cyc - r);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_read_zero();
        drive_read(0, 7'd0, 1);
        drive_idle(1);
        drive_read(0, 7'd63, 1);
        drive_idle(1);
        drive_read(0, 7'd127, 1);
        drive_idle(2);
    endtask

    task automatic test_masked_write();
        logic [DW-1:0] wd;
        wd = 44'hABC_DEF0_1234;
        drive_write(0, 7'd5, wd, 4'b0101, 1);
        drive_read(0, 7'd5, 1);
        drive_idle(1);
        n_total++;
        if (rdata[0] !== (wd & {11'h000, 11'h7FF, 11'h000, 11'h7FF}))
            $display("FAIL masked_write_0101 got %h want %h", rdata[0], wd & {11'h000, 11'h7FF, 11'h000, 11'h7FF});
        else n_pass++;
        drive_write(0, 7'd5, 44'h123_4567_89AB, 4'b1010, 1);
        drive_read(0, 7'd5, 1);
        drive_write(0, 7'd5, '1, 4'b0000, 1);
        drive_read(0, 7'd5, 1);
        drive_idle(2);
    endtask

    task automatic test_write_then_read();
        drive_write(0, 7'd9, 44'h5A5_A5A5_A5A5, 4'hF, 1);
        drive_read(0, 7'd9, 1);
        drive_write(0, 7'd9, 44'h0F0_F0F0_F0F0, 4'hF, 1);
        drive_read(0, 7'd9, 1);
        drive_idle(2);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v3;
        drive_write(1, 7'd1, 44'h111_1111_1111, 4'hF, 1);
        drive_write(1, 7'd2, 44'h222_2222_2222, 4'hF, 1);
        drive_write(1, 7'd3, 44'h333_3333_3333, 4'hF, 1);
        v3 = mdl[1][3];
        drive_read(1, 7'd1, 1);
        drive_read(1, 7'd2, 1);
        drive_read(1, 7'd3, 1);
        drive_write(1, 7'd3, 44'h777_0000_7777, 4'hF, 1);
        drive_idle(0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if (rdata[1] !== v3 || rvalid[1] !== 1'b0)
                $display("FAIL hold_rdata idle%0d got %h/%b want %h/0", i, rdata[1], rvalid[1], v3);
            else n_pass++;
        end
        drive_read(1, 7'd3, 1);
        drive_idle(3);
    endtask

    task automatic test_clear_ignore();
        int r;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        clear_model(1);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        r = cyc;
        drive_write(1, 7'd10, {4{11'h7FF}}, 4'hF, 0);
        drive_write(1, 7'd1, '1, 4'hF, 0);
        drive_read(1, 7'd2, 0);
        drive_idle(0);
        while (cyc - r <= dep[1]) begin
            @(negedge clk);
            if (cyc - r == dep[1] - 1) begin
                n_total++;
                if (init_done[1] !== 1'b0) $display("FAIL clr_init_early got %b want 0", init_done[1]); else n_pass++;
            end else if (cyc - r == dep[1]) begin
                n_total++;
                if (init_done[1] !== 1'b1) $display("FAIL clr_init_rise got %b want 1", init_done[1]); else n_pass++;
            end
        end
        drive_read(1, 7'd10, 1);
        drive_read(1, 7'd1, 1);
        drive_read(1, 7'd2, 1);
        drive_idle(3);
    endtask

    task automatic test_out_of_range();
        drive_write(2, 7'd99, 44'h3C3_C3C3_C3C3, 4'hF, 1);
        drive_write(2, 7'd120, 44'h6B6_B6B6_B6B6, 4'hF, 1);
        drive_read(2, 7'd99, 1);
        drive_read(2, 7'd120, 1);
        drive_read(2, 7'd99, 1);
        drive_idle(2);
    endtask

    task automatic test_reset_midflight();
        int r;
        // Latency-2 instance: reset with two reads still in the pipe.
        drive_write(1, 7'd5, 44'h155_2AA_1552, 4'hF, 1);
        drive_write(1, 7'd6, 44'h2AA_1552_AA1, 4'hF, 1);
        drive_read(1, 7'd5, 1);
        drive_idle(3);
        drive_read(1, 7'd5, 1);
        drive_read(1, 7'd6, 1);
        @(posedge clk); #1;
        en = '0;
        rst[1] = 1'b1;
        #1;
        n_total++;
        if (rvalid[1] !== 1'b0 || rdata[1] !== '0)
            $display("FAIL midflight_reset_lat2 got %b/%h want 0/0", rvalid[1], rdata[1]);
        else n_pass++;
        clear_model(1);
        @(posedge clk); #1;
        n_total++;
        if (rvalid[1] !== 1'b0 || init_done[1] !== 1'b0)
            $display("FAIL midflight_hold_lat2 got rvalid %b init_done %b want 0/0", rvalid[1], init_done[1]);
        else n_pass++;
        rst[1] = 1'b0;
        r = cyc;
        while (cyc - r <= dep[1]) begin
            @(negedge clk);
            if (cyc - r == dep[1]) begin
                n_total++;
                if (init_done[1] !== 1'b1) $display("FAIL resweep_init_lat2 got %b want 1", init_done[1]); else n_pass++;
            end
        end
        for (int a = 0; a < 16; a++) drive_read(1, 7'(a), 1);
        drive_idle(3);

        // Latency-1 instance: reset while holding nonzero read data.
        drive_write(0, 7'd127, 44'hFED_CBA9_8765, 4'hF, 1);
        drive_read(0, 7'd127, 1);
        drive_idle(1);
        @(posedge clk); #1;
        rst[0] = 1'b1;
        #1;
        n_total++;
        if (rdata[0] !== '0 || rvalid[0] !== 1'b0 || init_done[0] !== 1'b0)
            $display("FAIL midflight_reset_lat1 got %h/%b/%b want 0/0/0", rdata[0], rvalid[0], init_done[0]);
        else n_pass++;
        clear_model(0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        r = cyc;
        while (cyc - r <= dep[0]) begin
            @(negedge clk);
            if (cyc - r == dep[0] - 1) begin
                n_total++;
                if (init_done[0] !== 1'b0) $display("FAIL resweep_early_lat1 got %b want 0", init_done[0]); else n_pass++;
            end else if (cyc - r == dep[0]) begin
                n_total++;
                if (init_done[0] !== 1'b1) $display("FAIL resweep_init_lat1 got %b want 1", init_done[0]); else n_pass++;
            end
        end
        drive_read(0, 7'd0, 1);
        drive_read(0, 7'd5, 1);
        drive_read(0, 7'd9, 1);
        drive_read(0, 7'd127, 1);
        drive_idle(3);
    endtask

    initial begin
        dep[0] = 128; lat[0] = 1;
        dep[1] = 16;  lat[1] = 2;
        dep[2] = 100; lat[2] = 1;
        rst = '1; en = '0; addr = '0; wmode = 1'b0; wmask = '0; wdata = '0;

        test_reset();
        test_read_zero();
        test_masked_write();
        test_write_then_read();
        test_back_to_back();
        test_clear_ignore();
        test_out_of_range();
        test_reset_midflight();

        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_total++;
            if (sb_q[d].size() != 0) $display("FAIL pending_reads dut%0d got %0d left want 0", d, sb_q[d].size());
            else n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
